// File: rtl/uart_tx_param.sv
// uart_tx_param: bclk-paced UART transmitter, 5..DATA_WIDTH data bits.
// Define UART_TX_PARITY_EN to build the PARITY state and parity_mode.
module uart_tx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int OS_RATE    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bclk,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [3:0]            data_bits,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CW = $clog2(2 * OS_RATE);
  localparam logic [CW-1:0] LAST1 = CW'(OS_RATE - 1);
  localparam logic [CW-1:0] LAST2 = CW'(2 * OS_RATE - 1);
  localparam logic [3:0] NMAX = 4'(DATA_WIDTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state_q, state_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [3:0]            nb_q, nb_d;
  logic                  s2_q, s2_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
  logic [1:0] pm_q, pm_d;
  logic       par_on;
  assign par_on = pm_q[0] ^ pm_q[1];
`else
  logic unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  logic [CW-1:0] last;
  logic          tick_end;
  logic          accept;
  logic          last_bit;
  logic [3:0]    nb_clamp;

  assign last     = (state_q == STOP && s2_q) ? LAST2 : LAST1;
  assign tick_end = bclk && (cnt_q == last);
  assign accept   = (state_q == IDLE) && tx_start && !done_q;
  assign last_bit = (idx_q == nb_q - 4'd1);

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_done = done_q;

  // Clamp the requested frame length into 5..DATA_WIDTH
  always_comb begin
    nb_clamp = data_bits;
    unique case (1'b1)
      (data_bits < 4'd5):  nb_clamp = 4'd5;
      (data_bits > NMAX):  nb_clamp = NMAX;
      default: ;
    endcase
  end

  // State and datapath registers; reset parks the line high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      nb_q    <= '0;
      s2_q    <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
      pm_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      nb_q    <= nb_d;
      s2_q    <= s2_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
      pm_q    <= pm_d;
`endif
    end
  end

  // Next-state: each bit advances only on its final bclk tick
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = START;
      START: if (tick_end) state_d = DATA;
      DATA: begin
        if (tick_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_on ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick_end) state_d = STOP;
`endif
      STOP:  if (tick_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch frame at accept, count ticks, shift data out
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    sh_d  = sh_q;
    nb_d  = nb_q;
    s2_d  = s2_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
    pm_d  = pm_q;
`endif
    if (accept) begin
      cnt_d = '0;
      idx_d = '0;
      sh_d  = din;
      nb_d  = nb_clamp;
      s2_d  = stop2;
`ifdef UART_TX_PARITY_EN
      par_d = 1'b0;
      pm_d  = parity_mode;
`endif
    end else if (state_q != IDLE && bclk) begin
      cnt_d = tick_end ? '0 : cnt_q + 1'b1;
      if (tick_end && state_q == START) begin
        idx_d = '0;
      end
      if (tick_end && state_q == DATA) begin
        idx_d = idx_q + 4'd1;
        sh_d  = sh_q >> 1;
`ifdef UART_TX_PARITY_EN
        par_d = par_q ^ sh_q[0];
`endif
      end
    end
  end

  // Outputs: line level follows the state being entered
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_d ^ pm_d[1];
`endif
      default: tx_d = 1'b1;
    endcase
    done_d = (state_q == STOP) && tick_end;
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: randomized frames against a bit-list model.
// Parity expectations follow UART_TX_PARITY_EN when defined.
module tb_uart_tx_param;

  localparam int DW = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bclk = 1'b0;
  logic          tx_start = 1'b0;
  logic [DW-1:0] din = '0;
  logic [3:0]    data_bits = 4'd8;
  logic [1:0]    parity_mode = 2'b00;
  logic          stop2 = 1'b0;
  logic          tx;
  logic          tx_busy;
  logic          tx_done;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_param #(.DATA_WIDTH(DW), .OS_RATE(OS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bclk(bclk),
    .tx_start(tx_start),
    .din(din),
    .data_bits(data_bits),
    .parity_mode(parity_mode),
    .stop2(stop2),
    .tx(tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic run_frame(input logic [DW-1:0] d, input logic [3:0] nb,
                           input logic [1:0] pm, input logic s2,
                           input bit noise, input int stop_at);
    logic exp_bits[$];
    logic obs[$];
    int   n;
    int   ones;
    int   ticks;
    int   cyc;
    bit   busy_ok;
    bit   seen_done;
    bit   bad;
    n = (nb < 5) ? 5 : ((nb > DW) ? DW : int'(nb));
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
`ifdef UART_TX_PARITY_EN
    if (pm == 2'b01) exp_bits.push_back(ones % 2 == 1);
    else if (pm == 2'b10) exp_bits.push_back(ones % 2 == 0);
`endif
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);

    @(negedge clk);
    tx_start = 1'b1;
    din = d;
    data_bits = nb;
    parity_mode = pm;
    stop2 = s2;
    bclk = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    n_cmp++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL accept: tx=%b busy=%b, want tx=0 busy=1", tx, tx_busy);
    end

    ticks = 0;
    cyc = 0;
    busy_ok = 1;
    seen_done = 0;
    while (!seen_done && cyc < 4000) begin
      if (tx_done === 1'b1) begin
        seen_done = 1;
      end else begin
        if (tx_busy !== 1'b1) busy_ok = 0;
        if (stop_at >= 0 && ticks == stop_at) begin
          bclk = 1'b0;
          tx_start = 1'b0;
          return;
        end
        bclk = 1'($urandom_range(0, 1));
        if (bclk) begin
          obs.push_back(tx);
          ticks++;
        end
        if (noise) begin
          din = DW'($urandom);
          data_bits = 4'($urandom);
          parity_mode = 2'($urandom);
          stop2 = 1'($urandom);
          tx_start = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        cyc++;
      end
    end

    bclk = 1'b0;
    tx_start = 1'b0;
    n_cmp++;
    if (!seen_done) begin
      n_err++;
      $display("FAIL done_timeout: no tx_done after %0d ticks, want %0d",
               ticks, exp_bits.size() * OS);
      return;
    end

    n_cmp++;
    if (ticks != exp_bits.size() * OS) begin
      n_err++;
      $display("FAIL frame_len: %0d ticks, want %0d", ticks, exp_bits.size() * OS);
    end

    for (int b = 0; b < exp_bits.size(); b++) begin
      bad = 0;
      for (int k = 0; k < OS; k++) begin
        if (b * OS + k >= obs.size()) bad = 1;
        else if (obs[b * OS + k] !== exp_bits[b]) bad = 1;
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL bit%0d din=%h: line not steady %b for %0d ticks",
                 b, d, exp_bits[b], OS);
      end
    end

    n_cmp++;
    if (!busy_ok) begin
      n_err++;
      $display("FAIL busy: tx_busy dropped mid-frame, want 1");
    end

    n_cmp++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_cycle: tx=%b busy=%b, want tx=1 busy=0", tx, tx_busy);
    end

    tx_start = 1'b1;
    din = DW'($urandom);
    @(negedge clk);
    tx_start = 1'b0;
    n_cmp++;
    if (tx_done !== 1'b0 || tx_busy !== 1'b0 || tx !== 1'b1) begin
      n_err++;
      $display("FAIL done_ignore: done=%b busy=%b tx=%b, want 0 0 1",
               tx_done, tx_busy, tx);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: tx=%b busy=%b done=%b, want 1 0 0",
               tx, tx_busy, tx_done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    run_frame(8'hA5, 4'd8, 2'b00, 1'b0, 0, -1);
  endtask

  task automatic test_parity();
    run_frame(8'hA5, 4'd8, 2'b01, 1'b0, 0, -1);
    run_frame(8'h41, 4'd7, 2'b01, 1'b1, 0, -1);
    run_frame(8'h41, 4'd7, 2'b10, 1'b0, 0, -1);
    run_frame(8'h13, 4'd5, 2'b10, 1'b0, 0, -1);
    run_frame(8'h13, 4'd3, 2'b10, 1'b0, 0, -1);
    run_frame(8'h0F, 4'd8, 2'b01, 1'b0, 0, -1);
    run_frame(8'hC3, 4'd15, 2'b11, 1'b1, 0, -1);
  endtask

  task automatic test_mid_start();
    run_frame(8'h3C, 4'd8, 2'b00, 1'b0, 1, -1);
    run_frame(8'h96, 4'd6, 2'b10, 1'b1, 1, -1);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(8'hE7, 4'd8, 2'b00, 1'b0, 0, 4 * OS + OS / 2);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: tx=%b busy=%b done=%b, want 1 0 0",
               tx, tx_busy, tx_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(8'h55, 4'd8, 2'b00, 1'b0, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      run_frame(DW'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                bit'($urandom_range(0, 1)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_mid_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
